// File: rtl/weather_pkg.sv
// Shared definitions for the weather event arbiter: source ids, FSM states,
// default coefficient/offset constants and the grant-selection helpers.
package weather_pkg;

  localparam logic [1:0] SRC_TEMP = 2'd0;
  localparam logic [1:0] SRC_HUMI = 2'd1;
  localparam logic [1:0] SRC_WIND = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] DEF_TEMP_COEF = 4'd3;
  localparam logic [7:0] DEF_TEMP_OFS  = 8'd43;
  localparam logic [3:0] DEF_HUMI_COEF = 4'd1;
  localparam logic [7:0] DEF_HUMI_OFS  = 8'd52;
  localparam logic [3:0] DEF_WIND_COEF = 4'd8;
  localparam logic [7:0] DEF_WIND_OFS  = 8'd19;

  function automatic logic [1:0] nextSrc(input logic [1:0] src);
    return (src == SRC_WIND) ? SRC_TEMP : src + 2'd1;
  endfunction

  // First pending source strictly after the last grant, wrapping back to it last.
  function automatic logic [1:0] rrPick(input logic [2:0] pending, input logic [1:0] last);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = nextSrc(last);
    c2 = nextSrc(c1);
    if (pending[c1])      return c1;
    else if (pending[c2]) return c2;
    else                  return last;
  endfunction

  function automatic logic [1:0] fixedPick(input logic [2:0] pending);
    if (pending[SRC_WIND])      return SRC_WIND;
    else if (pending[SRC_HUMI]) return SRC_HUMI;
    else                        return SRC_TEMP;
  endfunction

endpackage

// File: rtl/weather_shift_add_mac.sv
// Four-cycle shift-add engine: result = coef*mcand + ofs (mod 256).
// done and result are valid combinationally in the cycle that processes bit 3.
module weather_shift_add_mac (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] mcand,
  input  logic [3:0] coef,
  input  logic [7:0] ofs,
  output logic       done,
  output logic [7:0] result
);

  logic [7:0] r_mcand;
  logic [7:0] r_acc;
  logic [7:0] r_ofs;
  logic [3:0] r_coef;
  logic [1:0] r_bit;
  logic       r_run;
  logic [7:0] w_partial;
  logic [7:0] w_accNext;

  always_comb begin
    w_partial = r_coef[r_bit] ? (r_mcand << r_bit) : 8'd0;
    w_accNext = r_acc + w_partial;
  end

  assign done   = r_run && (r_bit == 2'd3);
  assign result = w_accNext + r_ofs;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_ofs   <= '0;
      r_coef  <= '0;
      r_bit   <= '0;
      r_run   <= 1'b0;
    end else if (start) begin
      r_mcand <= mcand;
      r_coef  <= coef;
      r_ofs   <= ofs;
      r_acc   <= '0;
      r_bit   <= '0;
      r_run   <= 1'b1;
    end else if (r_run) begin
      r_acc <= w_accNext;
      r_bit <= r_bit + 2'd1;
      if (r_bit == 2'd3) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/weather_event_arbiter.sv
// Shares one shift-add report engine between temp/humi/wind event lines.
// Define WEATHER_ARB_FIXED_PRIO_EN for fixed priority wind > humi > temp.
module weather_event_arbiter
  import weather_pkg::*;
#(
  parameter logic [3:0] TEMP_COEF = DEF_TEMP_COEF,
  parameter logic [7:0] TEMP_OFS  = DEF_TEMP_OFS,
  parameter logic [3:0] HUMI_COEF = DEF_HUMI_COEF,
  parameter logic [7:0] HUMI_OFS  = DEF_HUMI_OFS,
  parameter logic [3:0] WIND_COEF = DEF_WIND_COEF,
  parameter logic [7:0] WIND_OFS  = DEF_WIND_OFS
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       ev_temp,
  input  logic       ev_humi,
  input  logic       ev_wind,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] out_src,
  output logic [2:0] ovf,
  output logic       busy
);

  state_t     r_state;
  logic [7:0] r_count;
  logic [2:0] r_pending;
  logic [7:0] r_ts [3];
  logic [1:0] r_grant;
  logic       r_outValid;
  logic [7:0] r_outData;
  logic [1:0] r_outSrc;
  logic [2:0] r_ovf;
  logic       r_busy;
`ifndef WEATHER_ARB_FIXED_PRIO_EN
  logic [1:0] r_rrLast;
`endif

  logic [2:0] w_ev;
  logic       w_grantFire;
  logic [1:0] w_grantSrc;
  logic [2:0] w_clr;
  logic [7:0] w_mcand;
  logic [3:0] w_coef;
  logic [7:0] w_ofs;
  logic       w_macDone;
  logic [7:0] w_macResult;

  assign w_ev = {ev_wind, ev_humi, ev_temp};

  always_comb begin
    w_grantFire = (r_state == ST_IDLE) && (|r_pending);
`ifdef WEATHER_ARB_FIXED_PRIO_EN
    w_grantSrc  = fixedPick(r_pending);
`else
    w_grantSrc  = rrPick(r_pending, r_rrLast);
`endif
    w_clr = w_grantFire ? (3'b001 << w_grantSrc) : 3'b000;
    case (w_grantSrc)
      SRC_HUMI: begin w_mcand = r_ts[1]; w_coef = HUMI_COEF; w_ofs = HUMI_OFS; end
      SRC_WIND: begin w_mcand = r_ts[2]; w_coef = WIND_COEF; w_ofs = WIND_OFS; end
      default:  begin w_mcand = r_ts[0]; w_coef = TEMP_COEF; w_ofs = TEMP_OFS; end
    endcase
  end

  weather_shift_add_mac u_mac (
    .CLK    (CLK),
    .Reset  (Reset),
    .start  (w_grantFire),
    .mcand  (w_mcand),
    .coef   (w_coef),
    .ofs    (w_ofs),
    .done   (w_macDone),
    .result (w_macResult)
  );

  // A grant in the same cycle as a new event lets the event re-arm the flag.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_pending  <= '0;
      for (int i = 0; i < 3; i++) r_ts[i] <= '0;
      r_grant    <= SRC_TEMP;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSrc   <= '0;
      r_ovf      <= '0;
      r_busy     <= 1'b0;
`ifndef WEATHER_ARB_FIXED_PRIO_EN
      r_rrLast   <= SRC_WIND;
`endif
    end else begin
      r_count <= r_count + 8'd1;
      for (int i = 0; i < 3; i++) begin
        if (w_ev[i]) begin
          if (r_pending[i] && !w_clr[i]) begin
            r_ovf[i] <= 1'b1;
          end else begin
            r_pending[i] <= 1'b1;
            r_ts[i]      <= r_count;
          end
        end else if (w_clr[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_grantFire) begin
            r_grant  <= w_grantSrc;
`ifndef WEATHER_ARB_FIXED_PRIO_EN
            r_rrLast <= w_grantSrc;
`endif
            r_busy   <= 1'b1;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (w_macDone) begin
            r_outData  <= w_macResult;
            r_outSrc   <= r_grant;
            r_outValid <= 1'b1;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_src   = r_outSrc;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_weather_event_arbiter.sv
// Scoreboard bench for weather_event_arbiter: expected reports are queued as
// events are driven and checked as the DUT hands them over.
module tb_weather_event_arbiter;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       ev_temp;
  logic       ev_humi;
  logic       ev_wind;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic [2:0] ovf;
  logic       busy;

  int         nCompared = 0;
  int         nMismatched = 0;
  logic [9:0] expQ [$];
  logic [9:0] monExp;
  logic [7:0] tbCount;

  weather_event_arbiter dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .ev_temp   (ev_temp),
    .ev_humi   (ev_humi),
    .ev_wind   (ev_wind),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Reference timestamp counter, free-running like the design's.
  always @(posedge CLK) begin
    if (Reset) tbCount <= 8'd0;
    else       tbCount <= tbCount + 8'd1;
  end

  function automatic logic [7:0] tbModel(input logic [1:0] src, input logic [7:0] ts);
    int v;
    case (src)
      2'd0:    v = 3 * int'(ts) + 43;
      2'd1:    v = 1 * int'(ts) + 52;
      default: v = 8 * int'(ts) + 19;
    endcase
    return 8'(v);
  endfunction

  // Every accepted report is popped and compared against the queue head.
  always @(negedge CLK) begin
    if (!Reset && out_valid && out_ready) begin
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL unexpected_report: got src=%0d data=%0d, required no report", out_src, out_data);
      end else begin
        monExp = expQ.pop_front();
        if ({out_src, out_data} !== monExp) begin
          nMismatched++;
          $display("[TB] FAIL report: got src=%0d data=%0d, required src=%0d data=%0d",
                   out_src, out_data, monExp[9:8], monExp[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic pushExp(input logic [1:0] src, input logic [7:0] ts);
    expQ.push_back({src, tbModel(src, ts)});
  endtask

  task automatic applyStimulus(input logic [2:0] mask);
    {ev_wind, ev_humi, ev_temp} = mask;
    tick();
    {ev_wind, ev_humi, ev_temp} = 3'b000;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    expQ.delete();
  endtask

  task automatic waitCount(input logic [7:0] target);
    int n = 0;
    while (tbCount !== target && n < 300) begin tick(); n++; end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < budget) begin tick(); n++; end
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL drain_timeout: got %0d reports outstanding, required 0", expQ.size());
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    doReset();
    nCompared += 5;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b, required 0", out_valid); end
    if (busy !== 1'b0)      begin nMismatched++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    if (out_data !== 8'd0)  begin nMismatched++; $display("[TB] FAIL reset_data: got %0d, required 0", out_data); end
    if (out_src !== 2'd0)   begin nMismatched++; $display("[TB] FAIL reset_src: got %0d, required 0", out_src); end
    if (ovf !== 3'b000)     begin nMismatched++; $display("[TB] FAIL reset_ovf: got %b, required 000", ovf); end
  endtask

  task automatic test_latency();
    int lat = 0;
    doReset();
    waitCount(8'd5);
    pushExp(2'd0, tbCount);
    applyStimulus(3'b001);
    while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    nCompared++;
    if (lat != 5) begin nMismatched++; $display("[TB] FAIL latency: got %0d edges, required 5", lat); end
    waitDrain(40);
  endtask

  task automatic test_single(input logic [1:0] src, input logic [7:0] at);
    doReset();
    waitCount(at);
    pushExp(src, tbCount);
    applyStimulus(3'b001 << src);
    waitDrain(40);
  endtask

  task automatic test_wrap();
    doReset();
    waitCount(8'd250);
    pushExp(2'd2, tbCount);
    applyStimulus(3'b100);
    waitDrain(40);
    waitCount(8'd3);
    pushExp(2'd0, tbCount);
    applyStimulus(3'b001);
    waitDrain(40);
  endtask

  task automatic test_simultaneous();
    doReset();
`ifdef WEATHER_ARB_FIXED_PRIO_EN
    pushExp(2'd2, tbCount);
    pushExp(2'd1, tbCount);
    pushExp(2'd0, tbCount);
`else
    pushExp(2'd0, tbCount);
    pushExp(2'd1, tbCount);
    pushExp(2'd2, tbCount);
`endif
    applyStimulus(3'b111);
    waitDrain(60);
  endtask

  task automatic test_hold();
    int n = 0;
    logic [7:0] ts;
    doReset();
    out_ready = 1'b0;
    ts = tbCount;
    pushExp(2'd1, ts);
    applyStimulus(3'b010);
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        pushExp(2'd0, tbCount);
        applyStimulus(3'b001);
      end else begin
        tick();
      end
      nCompared += 3;
      if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL hold_valid: got %b, required 1", out_valid); end
      if (out_data !== tbModel(2'd1, ts)) begin
        nMismatched++; $display("[TB] FAIL hold_data: got %0d, required %0d", out_data, tbModel(2'd1, ts));
      end
      if (out_src !== 2'd1) begin nMismatched++; $display("[TB] FAIL hold_src: got %0d, required 1", out_src); end
    end
    out_ready = 1'b1;
    tick();
    nCompared += 2;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL accept_valid: got %b, required 0", out_valid); end
    if (busy !== 1'b0)      begin nMismatched++; $display("[TB] FAIL accept_idle: got busy=%b, required 0", busy); end
    tick();
    nCompared++;
    if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL next_grant: got busy=%b, required 1", busy); end
    waitDrain(40);
  endtask

  task automatic test_overflow();
    doReset();
    out_ready = 1'b1;
    pushExp(2'd2, tbCount);
    applyStimulus(3'b100);
    pushExp(2'd0, tbCount);
    applyStimulus(3'b001);
    applyStimulus(3'b001);
    applyStimulus(3'b001);
    nCompared++;
    if (ovf !== 3'b001) begin nMismatched++; $display("[TB] FAIL ovf_set: got %b, required 001", ovf); end
    waitDrain(60);
    for (int i = 0; i < 15; i++) tick();
    nCompared++;
    if (ovf !== 3'b001) begin nMismatched++; $display("[TB] FAIL ovf_sticky: got %b, required 001", ovf); end
  endtask

  task automatic test_reset_mid();
    int busyHits = 0;
    out_ready = 1'b1;
    pushExp(2'd0, tbCount);
    applyStimulus(3'b001);
    tick();
    tick();
    tick();
    Reset = 1'b1;
    expQ.delete();
    tick();
    nCompared += 3;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_valid: got %b, required 0", out_valid); end
    if (busy !== 1'b0)      begin nMismatched++; $display("[TB] FAIL midrst_busy: got %b, required 0", busy); end
    if (ovf !== 3'b000)     begin nMismatched++; $display("[TB] FAIL midrst_ovf: got %b, required 000", ovf); end
    Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy !== 1'b0) busyHits++;
    end
    nCompared++;
    if (busyHits != 0) begin nMismatched++; $display("[TB] FAIL midrst_pending: got %0d busy cycles, required 0", busyHits); end
    waitCount(8'd20);
    pushExp(2'd1, tbCount);
    applyStimulus(3'b010);
    waitDrain(40);
  endtask

  initial begin
    Reset     = 1'b1;
    ev_temp   = 1'b0;
    ev_humi   = 1'b0;
    ev_wind   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_latency();
    test_single(2'd1, 8'd10);
    test_single(2'd2, 8'd40);
    test_single(2'd0, 8'd200);
    test_wrap();
    test_simultaneous();
    test_hold();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
